sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_starve_cnt.sv | 32 +++
 rtl/sram_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
// Fetch fairness is built only when SRAM_ARB_FAIR_EN is defined.
package sram_arb_pkg;

  // Owner of the read response that returns one cycle after its grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // Starvation counter width; STARVE_MAX must fit in it (1..15).
  localparam int CNT_W = 4;

  function automatic logic is_read(input logic [3:0] we);
    return (we == 4'b0000);
  endfunction

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Counts consecutive cycles a fetch request is denied and forces the fetch
// through once the count reaches STARVE_MAX.
module sram_arb_starve_cnt
  import sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] SAT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!if_req || if_gnt) begin
      count <= '0;
    end else if (count != SAT_MAX) begin
      count <= count + 1'b1;
    end
  end

  assign force_if = (count == LIMIT);

endmodule

// File: rtl/sram_arbiter.sv
// Two-master (fetch / data) arbiter in front of a single-port SRAM with
// 1-cycle read latency. Define SRAM_ARB_FAIR_EN to enable forced fetch grants.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("sram_arbiter: STARVE_MAX must be in 1..15");
  end

  // Handshake: a request is accepted in the cycle where req && gnt; gnt is
  // combinational from req, and a read's rvalid/rdata follow exactly one
  // cycle later with no backpressure on the response side.

  logic   force_if;
  logic   force_win;
  owner_e owner_q;
  owner_e owner_d;

`ifdef SRAM_ARB_FAIR_EN
  sram_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .force_if(force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // A stale force with no fetch pending must not block the data port.
  assign force_win = force_if && if_req;
  assign dm_gnt    = !reset && dm_req && !force_win;
  assign if_gnt    = !reset && if_req && (!dm_req || force_win);

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = 32'h0;
    if (dm_gnt) begin
      sram_en    = 1'b1;
      sram_we    = dm_we;
      sram_addr  = dm_addr;
      sram_wdata = dm_wdata;
    end else if (if_gnt) begin
      sram_en   = 1'b1;
      sram_addr = if_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (dm_gnt && is_read(dm_we)) begin
      owner_d = OWN_DM;
    end else if (if_gnt) begin
      owner_d = OWN_IF;
    end
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign dm_rvalid = (owner_q == OWN_DM);
  assign if_rdata  = if_rvalid ? sram_rdata : 32'h0;
  assign dm_rdata  = dm_rvalid ? sram_rdata : 32'h0;

endmodule
